rf_sb: RTL and testbench

//  Integer register file (32 x XLEN) with a per-register busy scoreboard.

---
 rtl/rf_sb.sv | 91 +++++++++
 tb/tb_rf_sb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rf_sb.sv
// Integer register file (32 x XLEN, x0 hardwired to zero) with a per-register
// busy scoreboard for the issue stage, fed by the writeback arbiter.
module rf_sb #(
  parameter int XLEN   = 64,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rf_wen,
  input  logic [4:0]      rf_wdst,
  input  logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      rf_rsrc0,
  output logic [XLEN-1:0] rf_rdata0,
  output logic            rf_rbusy0,
  input  logic [4:0]      rf_rsrc1,
  output logic [XLEN-1:0] rf_rdata1,
  output logic            rf_rbusy1,
  input  logic            iss_set,
  input  logic [4:0]      iss_dst,
  output logic            iss_dst_busy,
  input  logic            sb_flush,
  output logic            sb_any_busy
);

  logic [XLEN-1:0] regs [32];
  logic [31:0]     busy;
  logic [31:0]     busy_nxt;
  logic            wr_en;
  logic            set_en;

  assign wr_en  = rf_wen && (rf_wdst != 5'd0);
  assign set_en = iss_set && (iss_dst != 5'd0);

  // Forwarding is suppressed while reset is held so every read port reads zero.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr,
                                                input logic [XLEN-1:0] arr_val);
    logic [XLEN-1:0] val;
    val = arr_val;
    if (addr == 5'd0)
      val = '0;
    else if ((BYPASS != 0) && rst && wr_en && (rf_wdst == addr))
      val = rf_wdata;
    return val;
  endfunction

  // A writeback to the register in the same cycle hides its pending status.
  function automatic logic busy_port(input logic [4:0] addr);
    return busy[addr] && !(rf_wen && (rf_wdst == addr));
  endfunction

  assign rf_rdata0    = read_port(rf_rsrc0, regs[rf_rsrc0]);
  assign rf_rdata1    = read_port(rf_rsrc1, regs[rf_rsrc1]);
  assign rf_rbusy0    = busy_port(rf_rsrc0);
  assign rf_rbusy1    = busy_port(rf_rsrc1);
  assign iss_dst_busy = busy_port(iss_dst);
  assign sb_any_busy  = |busy[31:1];

  // Priority: flush, then writeback clear, then issue set (new producer wins).
  always_comb begin
    busy_nxt = busy;
    if (sb_flush)
      busy_nxt = '0;
    if (wr_en)
      busy_nxt[rf_wdst] = 1'b0;
    if (set_en)
      busy_nxt[iss_dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_en)
        regs[rf_wdst] <= rf_wdata;
      busy <= busy_nxt;
    end
  end

  // Issuing to a register that still has an outstanding producer is a WAW bug upstream.
  property p_no_double_set;
    @(posedge clk) disable iff (!rst)
      set_en |-> (!busy[iss_dst] || sb_flush || (rf_wen && (rf_wdst == iss_dst)));
  endproperty

  a_no_double_set: assert property (p_no_double_set)
    else $error("rf_sb: iss_set to already-busy register x%0d", iss_dst);

endmodule

// File: tb/tb_rf_sb.sv
// Directed self-checking bench for rf_sb: reset, read/write, bypass,
// scoreboard set/clear, set/clear collision, flush and asynchronous reset.
module tb_rf_sb;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            rf_wen;
  logic [4:0]      rf_wdst;
  logic [XLEN-1:0] rf_wdata;
  logic [4:0]      rf_rsrc0;
  logic [XLEN-1:0] rf_rdata0;
  logic            rf_rbusy0;
  logic [4:0]      rf_rsrc1;
  logic [XLEN-1:0] rf_rdata1;
  logic            rf_rbusy1;
  logic            iss_set;
  logic [4:0]      iss_dst;
  logic            iss_dst_busy;
  logic            sb_flush;
  logic            sb_any_busy;

  int checks = 0;
  int errors = 0;

  rf_sb #(.XLEN(XLEN), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rf_wen(rf_wen), .rf_wdst(rf_wdst), .rf_wdata(rf_wdata),
    .rf_rsrc0(rf_rsrc0), .rf_rdata0(rf_rdata0), .rf_rbusy0(rf_rbusy0),
    .rf_rsrc1(rf_rsrc1), .rf_rdata1(rf_rdata1), .rf_rbusy1(rf_rbusy1),
    .iss_set(iss_set), .iss_dst(iss_dst), .iss_dst_busy(iss_dst_busy),
    .sb_flush(sb_flush), .sb_any_busy(sb_any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_wen   = 1'b0;
    iss_set  = 1'b0;
    sb_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rf_wen = 1'b1; rf_wdst = 5'd1; rf_wdata = 64'hAAAA_5555_AAAA_5555;
    rf_rsrc0 = 5'd1; rf_rsrc1 = 5'd0; iss_set = 1'b0; iss_dst = 5'd0; sb_flush = 1'b0;

    // T1: reset held with a write pending
    tick(); tick();
    chk("rst_rdata0_held", rf_rdata0, '0);
    chk("rst_anybusy_held", {63'd0, sb_any_busy}, 64'd0);
    idle();
    rst = 1'b1;
    tick();
    for (int i = 1; i < 32; i++) begin
      rf_rsrc0 = 5'(i);
      rf_rsrc1 = 5'(i);
      #1;
      chk($sformatf("rst_x%0d_rdata0", i), rf_rdata0, '0);
      chk($sformatf("rst_x%0d_busy", i), {62'd0, rf_rbusy0, rf_rbusy1}, 64'd0);
    end
    chk("rst_anybusy", {63'd0, sb_any_busy}, 64'd0);

    // T2: write then read; x0 write ignored
    rf_wen = 1'b1; rf_wdst = 5'd5; rf_wdata = 64'hDEADBEEF_00000001;
    tick();
    idle(); rf_rsrc0 = 5'd5; #1;
    chk("wr_x5", rf_rdata0, 64'hDEADBEEF_00000001);
    rf_wen = 1'b1; rf_wdst = 5'd0; rf_wdata = 64'hFFFF; rf_rsrc0 = 5'd0; #1;
    chk("x0_bypass", rf_rdata0, '0);
    tick();
    idle(); #1;
    chk("x0_after", rf_rdata0, '0);

    // T3: same-cycle bypass on port 1
    rf_wen = 1'b1; rf_wdst = 5'd7; rf_wdata = 64'h1234; rf_rsrc1 = 5'd7; #1;
    chk("bypass_x7", rf_rdata1, 64'h1234);
    tick();
    idle(); #1;
    chk("x7_stored", rf_rdata1, 64'h1234);

    // T4: scoreboard set then clear by writeback
    iss_set = 1'b1; iss_dst = 5'd3;
    tick();
    idle(); rf_rsrc0 = 5'd3; #1;
    chk("sb_rbusy0_x3", {63'd0, rf_rbusy0}, 64'd1);
    chk("sb_dstbusy_x3", {63'd0, iss_dst_busy}, 64'd1);
    chk("sb_anybusy_x3", {63'd0, sb_any_busy}, 64'd1);
    rf_wen = 1'b1; rf_wdst = 5'd3; rf_wdata = 64'h33; #1;
    chk("sb_rbusy0_wb", {63'd0, rf_rbusy0}, 64'd0);
    chk("sb_dstbusy_wb", {63'd0, iss_dst_busy}, 64'd0);
    chk("sb_rdata0_wb", rf_rdata0, 64'h33);
    chk("sb_anybusy_unmasked", {63'd0, sb_any_busy}, 64'd1);
    tick();
    idle(); #1;
    chk("sb_rbusy0_after", {63'd0, rf_rbusy0}, 64'd0);
    chk("sb_anybusy_after", {63'd0, sb_any_busy}, 64'd0);

    // iss_set to x0 is ignored
    iss_set = 1'b1; iss_dst = 5'd0;
    tick();
    idle(); #1;
    chk("x0_set_anybusy", {63'd0, sb_any_busy}, 64'd0);
    chk("x0_dstbusy", {63'd0, iss_dst_busy}, 64'd0);

    // T5: collision (set wins, data lands), then flush with concurrent set
    rf_wen = 1'b1; rf_wdst = 5'd9; rf_wdata = 64'h99; iss_set = 1'b1; iss_dst = 5'd9;
    tick();
    idle(); rf_rsrc0 = 5'd9; #1;
    chk("coll_data_x9", rf_rdata0, 64'h99);
    chk("coll_busy_x9", {63'd0, rf_rbusy0}, 64'd1);
    sb_flush = 1'b1; iss_set = 1'b1; iss_dst = 5'd4;
    rf_wen = 1'b1; rf_wdst = 5'd10; rf_wdata = 64'hA0;
    tick();
    idle(); rf_rsrc1 = 5'd4; iss_dst = 5'd9; #1;
    chk("flush_busy_x9", {63'd0, rf_rbusy0}, 64'd0);
    chk("flush_dstbusy_x9", {63'd0, iss_dst_busy}, 64'd0);
    chk("flush_busy_x4", {63'd0, rf_rbusy1}, 64'd1);
    chk("flush_anybusy", {63'd0, sb_any_busy}, 64'd1);
    rf_rsrc1 = 5'd10; #1;
    chk("flush_write_x10", rf_rdata1, 64'hA0);
    rf_wen = 1'b1; rf_wdst = 5'd4; rf_wdata = 64'h44;
    tick();
    idle(); #1;
    chk("clear_x4_anybusy", {63'd0, sb_any_busy}, 64'd0);

    // T6: asynchronous reset between edges
    iss_set = 1'b1; iss_dst = 5'd2;
    tick();
    iss_dst = 5'd3;
    tick();
    idle(); rf_rsrc0 = 5'd2; rf_rsrc1 = 5'd3; iss_dst = 5'd3; #1;
    chk("pre_rst_busy_x2", {63'd0, rf_rbusy0}, 64'd1);
    chk("pre_rst_data_x3", rf_rdata1, 64'h33);
    chk("pre_rst_anybusy", {63'd0, sb_any_busy}, 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy_x2", {63'd0, rf_rbusy0}, 64'd0);
    chk("arst_data_x3", rf_rdata1, '0);
    chk("arst_dstbusy", {63'd0, iss_dst_busy}, 64'd0);
    chk("arst_anybusy", {63'd0, sb_any_busy}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_x3", rf_rdata1, '0);
    chk("post_rst_busy_x3", {63'd0, rf_rbusy1}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
